// File: rtl/c5_pipe_ctrl_pkg.sv
// Shared definitions for the c5 pipeline sequencing controller:
// FSM encodings, the hard-wired zero register index and default sizes.
package c5_pipe_ctrl_pkg;

  // Multi-cycle (mult/div) tracking states.
  typedef enum logic {
    PC_IDLE    = 1'b0,
    PC_MC_BUSY = 1'b1
  } pc_state_e;

  // Register 0 is hard-wired to zero and never creates a hazard.
  localparam logic [4:0] REG_ZERO = 5'd0;

  // Default parameter values.
  localparam int DEFAULT_TIMEOUT = 1024;
  localparam int DEFAULT_CNT_W   = 16;

endpackage

// File: rtl/c5_stall_monitor.sv
// Stall bookkeeping: saturating count of decode-stall cycles, run length of
// consecutive fetch stalls, and a sticky stuck-pipeline flag.
module c5_stall_monitor
  import c5_pipe_ctrl_pkg::*;
#(
  parameter int TIMEOUT = DEFAULT_TIMEOUT,
  parameter int CNT_W   = DEFAULT_CNT_W
) (
  input  logic             I_clk,
  input  logic             I_rst,
  input  logic             stall_d,
  input  logic             stall_f,
  output logic [CNT_W-1:0] stall_count,
  output logic             timeout
);

  localparam int RUN_W = $clog2(TIMEOUT + 1);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(TIMEOUT);

  logic [RUN_W-1:0] run_q;
  logic [RUN_W-1:0] run_next;

  // Next run length: grows while fetch stalls (held at TIMEOUT), clears otherwise.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    run_next = '0;
    if (stall_f) begin
      run_next = (run_q == RUN_MAX) ? run_q : run_q + RUN_W'(1);
    end
  end

  // Counters and sticky flag; reset is synchronous to match the rest of the core.
  always_ff @(posedge I_clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (I_rst) begin
      stall_count <= '0;
      run_q       <= '0;
      timeout     <= 1'b0;
    end else begin
      if (stall_d && (stall_count != '1)) begin
        stall_count <= stall_count + CNT_W'(1);
      end
      run_q <= run_next;
      if (run_next == RUN_MAX) begin
        timeout <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/c5_pipe_ctrl.sv
// Pipeline sequencing controller: prioritised stall/flush/bubble generation,
// multi-cycle operation tracking and stall monitoring.
module c5_pipe_ctrl
  import c5_pipe_ctrl_pkg::*;
#(
  parameter int TIMEOUT = DEFAULT_TIMEOUT,
  parameter int CNT_W   = DEFAULT_CNT_W
) (
  input  logic             I_clk,
  input  logic             I_rst,
  input  logic [4:0]       I_d_rs,
  input  logic             I_d_rs_used,
  input  logic [4:0]       I_d_rt,
  input  logic             I_d_rt_used,
  input  logic             I_d_mc_use,
  input  logic [4:0]       I_e_rd,
  input  logic             I_e_is_load,
  input  logic             I_e_mc_start,
  input  logic             I_e_redirect,
  input  logic             I_mc_done,
  input  logic             I_m_busy,
  input  logic             I_imem_ready,
  output logic             O_stall_f,
  output logic             O_stall_d,
  output logic             O_flush_d,
  output logic             O_bubble_e,
  output logic             O_stall_e,
  output logic             O_stall_m,
  output logic             O_mc_busy,
  output logic             O_timeout,
  output logic [CNT_W-1:0] O_stall_count
);

  pc_state_e state_q;
  pc_state_e state_next;
  logic      load_use;
  logic      mc_hazard;
  logic      mc_accept;

  // Hazard detection; a done pulse releases the mc hazard in the same cycle.
  assign load_use  = I_e_is_load && (I_e_rd != REG_ZERO) &&
                     ((I_d_rs_used && (I_d_rs == I_e_rd)) ||
                      (I_d_rt_used && (I_d_rt == I_e_rd)));
  assign mc_hazard = (state_q == PC_MC_BUSY) && I_d_mc_use && !I_mc_done;
  assign mc_accept = I_e_mc_start && !O_stall_e;
  assign O_mc_busy = (state_q == PC_MC_BUSY);

  // Prioritised control outputs and FSM next state.
  always_comb begin
    O_stall_f  = 1'b0;
    O_stall_d  = 1'b0;
    O_flush_d  = 1'b0;
    O_bubble_e = 1'b0;
    O_stall_e  = 1'b0;
    O_stall_m  = 1'b0;
    state_next = state_q;

    if (I_rst) begin
      // Controls are quiet while reset is held.
    end else if (I_m_busy) begin
      // Whole pipe holds; a pending redirect stays in execute until the wait ends.
      O_stall_f = 1'b1;
      O_stall_d = 1'b1;
      O_stall_e = 1'b1;
      O_stall_m = 1'b1;
    end else if (I_e_redirect) begin
      O_flush_d  = 1'b1;
      O_bubble_e = 1'b1;
    end else begin
      if (load_use || mc_hazard) begin
        O_stall_f  = 1'b1;
        O_stall_d  = 1'b1;
        O_bubble_e = 1'b1;
      end
      if (!I_imem_ready) begin
        O_stall_f = 1'b1;
        O_flush_d = !O_stall_d;
      end
    end

    case (state_q)
      PC_IDLE:    if (mc_accept) state_next = PC_MC_BUSY;
      PC_MC_BUSY: if (I_mc_done) state_next = mc_accept ? PC_MC_BUSY : PC_IDLE;
      default:    state_next = PC_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge I_clk) begin
    if (I_rst) state_q <= PC_IDLE;
    else       state_q <= state_next;
  end

  c5_stall_monitor #(
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) u_stall_monitor (
    .I_clk       (I_clk),
    .I_rst       (I_rst),
    .stall_d     (O_stall_d),
    .stall_f     (O_stall_f),
    .stall_count (O_stall_count),
    .timeout     (O_timeout)
  );

endmodule

// File: tb/tb_c5_pipe_ctrl.sv
// Self-checking bench for c5_pipe_ctrl (TIMEOUT=8, CNT_W=4): a vector table for
// the combinational priority logic plus hand-written multi-cycle sequences.
module tb_c5_pipe_ctrl;

  localparam int TIMEOUT = 8;
  localparam int CNT_W   = 4;

  typedef struct packed {
    logic [4:0] rs;
    logic       rs_used;
    logic [4:0] rt;
    logic       rt_used;
    logic       mc_use;
    logic [4:0] e_rd;
    logic       is_load;
    logic       mc_start;
    logic       redirect;
    logic       mc_done;
    logic       m_busy;
    logic       imem_ready;
  } in_t;

  // {stall_f, stall_d, flush_d, bubble_e, stall_e, stall_m}
  typedef logic [5:0] ctl_t;

  typedef struct {
    string name;
    in_t   in;
    ctl_t  exp;
  } vec_t;

  typedef struct {
    string name;
    ctl_t  exp;
  } sb_t;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  in_t              cur;
  logic             stall_f, stall_d, flush_d, bubble_e, stall_e, stall_m;
  logic             mc_busy, timeout;
  logic [CNT_W-1:0] stall_count;

  int   n_checks = 0;
  int   n_pass   = 0;
  vec_t tbl[$];
  sb_t  sb[$];

  always #5 clk = ~clk;

  c5_pipe_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .I_clk         (clk),
    .I_rst         (rst),
    .I_d_rs        (cur.rs),
    .I_d_rs_used   (cur.rs_used),
    .I_d_rt        (cur.rt),
    .I_d_rt_used   (cur.rt_used),
    .I_d_mc_use    (cur.mc_use),
    .I_e_rd        (cur.e_rd),
    .I_e_is_load   (cur.is_load),
    .I_e_mc_start  (cur.mc_start),
    .I_e_redirect  (cur.redirect),
    .I_mc_done     (cur.mc_done),
    .I_m_busy      (cur.m_busy),
    .I_imem_ready  (cur.imem_ready),
    .O_stall_f     (stall_f),
    .O_stall_d     (stall_d),
    .O_flush_d     (flush_d),
    .O_bubble_e    (bubble_e),
    .O_stall_e     (stall_e),
    .O_stall_m     (stall_m),
    .O_mc_busy     (mc_busy),
    .O_timeout     (timeout),
    .O_stall_count (stall_count)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // One cycle: drive inputs, queue the expected controls, compare mid-cycle,
  // then return just after the closing edge.
  task automatic apply(input string name, input in_t in, input ctl_t exp);
    sb_t e;
    cur = in;
    e.name = name;
    e.exp  = exp;
    sb.push_back(e);
    @(negedge clk);
    e = sb.pop_front();
    check(e.name, 32'({stall_f, stall_d, flush_d, bubble_e, stall_e, stall_m}), 32'(e.exp));
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic add(input string name, input in_t in, input ctl_t exp);
    vec_t v;
    v.name = name;
    v.in   = in;
    v.exp  = exp;
    tbl.push_back(v);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    in_t base, lu, t;

    base = '0;
    base.imem_ready = 1'b1;
    lu = base;
    lu.is_load = 1'b1;
    lu.e_rd    = 5'd5;
    lu.rs      = 5'd5;
    lu.rs_used = 1'b1;

    // ---- Reset: controls forced quiet even with hazards present ----
    t = lu;
    t.m_busy = 1'b1;
    t.imem_ready = 1'b0;
    cur = t;
    rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("rst_ctl", 32'({stall_f, stall_d, flush_d, bubble_e, stall_e, stall_m}), 32'(6'b000000));
    @(posedge clk); #1;
    check("rst_mc_busy", 32'(mc_busy), 32'(0));
    check("rst_timeout", 32'(timeout), 32'(0));
    check("rst_count", 32'(stall_count), 32'(0));
    rst = 1'b0;

    // ---- Vector table (state IDLE throughout) ----
    add("nominal", base, 6'b000000);
    add("lu_rs", lu, 6'b110100);
    t = lu; t.rs_used = 1'b0; t.rt = 5'd5; t.rt_used = 1'b1;
    add("lu_rt", t, 6'b110100);
    t = lu; t.e_rd = 5'd0; t.rs = 5'd0;
    add("lu_reg0", t, 6'b000000);
    t = lu; t.rs_used = 1'b0; t.rt = 5'd5;
    add("lu_unused", t, 6'b000000);
    t = lu; t.is_load = 1'b0;
    add("no_load", t, 6'b000000);
    t = lu; t.redirect = 1'b1;
    add("redir_over_lu", t, 6'b001100);
    t = lu; t.redirect = 1'b1; t.m_busy = 1'b1;
    add("mbusy_over_redir", t, 6'b110011);
    t = base; t.imem_ready = 1'b0;
    add("fetch_miss", t, 6'b101000);
    t = lu; t.imem_ready = 1'b0;
    add("miss_with_lu", t, 6'b110100);
    t = base; t.imem_ready = 1'b0; t.redirect = 1'b1;
    add("miss_with_redir", t, 6'b001100);
    t = base; t.mc_use = 1'b1;
    add("mc_use_idle", t, 6'b000000);
    foreach (tbl[i]) apply(tbl[i].name, tbl[i].in, tbl[i].exp);

    // ---- Load-use: one stall cycle, counted once ----
    do_reset();
    apply("lu_seq_stall", lu, 6'b110100);
    apply("lu_seq_after", base, 6'b000000);
    check("lu_seq_count", 32'(stall_count), 32'(1));
    t = lu; t.e_rd = 5'd0; t.rs = 5'd0;
    apply("lu_seq_rd0", t, 6'b000000);
    check("lu_seq_rd0_count", 32'(stall_count), 32'(1));

    // ---- Redirect + load-use: flush, nothing counted ----
    t = lu; t.redirect = 1'b1;
    apply("redir_lu_seq", t, 6'b001100);
    check("redir_lu_count", 32'(stall_count), 32'(1));

    // ---- Memory wait holding a redirect, flush when wait ends ----
    t = lu; t.redirect = 1'b1; t.m_busy = 1'b1;
    apply("mbusy_redir_1", t, 6'b110011);
    apply("mbusy_redir_2", t, 6'b110011);
    t.m_busy = 1'b0;
    apply("mbusy_drop_flush", t, 6'b001100);
    check("mbusy_count", 32'(stall_count), 32'(3));

    // ---- Multi-cycle op: stall cycles 1-5, release on done in cycle 6 ----
    do_reset();
    t = base; t.mc_start = 1'b1;
    apply("mc_start", t, 6'b000000);
    check("mc_busy_rise", 32'(mc_busy), 32'(1));
    t = base; t.mc_use = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      apply($sformatf("mc_stall_c%0d", c), t, 6'b110100);
      check($sformatf("mc_busy_c%0d", c), 32'(mc_busy), 32'(1));
    end
    t.mc_done = 1'b1;
    apply("mc_done_release", t, 6'b000000);
    check("mc_busy_fall", 32'(mc_busy), 32'(0));
    check("mc_count", 32'(stall_count), 32'(5));
    t = base; t.mc_use = 1'b1;
    apply("mc_idle_no_stall", t, 6'b000000);

    // ---- Start refused under memory wait ----
    t = base; t.mc_start = 1'b1; t.m_busy = 1'b1;
    apply("mc_start_blocked", t, 6'b110011);
    check("mc_blocked_idle", 32'(mc_busy), 32'(0));

    // ---- Done and accepted start in the same cycle stay busy ----
    t = base; t.mc_start = 1'b1;
    apply("mc_start2", t, 6'b000000);
    t.mc_done = 1'b1;
    apply("mc_done_start", t, 6'b000000);
    check("mc_done_start_busy", 32'(mc_busy), 32'(1));
    t = base; t.mc_done = 1'b1;
    apply("mc_done2", t, 6'b000000);
    check("mc_done2_idle", 32'(mc_busy), 32'(0));

    // ---- Reset mid-operation abandons the op ----
    t = base; t.mc_start = 1'b1;
    apply("mc_start3", t, 6'b000000);
    check("mc_busy3", 32'(mc_busy), 32'(1));
    cur = base;
    do_reset();
    check("rst_mid_mc_busy", 32'(mc_busy), 32'(0));
    check("rst_mid_count", 32'(stall_count), 32'(0));
    check("rst_mid_timeout", 32'(timeout), 32'(0));
    t = base; t.mc_use = 1'b1;
    apply("rst_mid_no_hazard", t, 6'b000000);
    t = base; t.mc_done = 1'b1;
    apply("late_done_idle", t, 6'b000000);
    check("late_done_mc_busy", 32'(mc_busy), 32'(0));

    // ---- Timeout: 8 consecutive stalls set the sticky flag ----
    do_reset();
    t = base; t.m_busy = 1'b1;
    for (int c = 1; c <= 7; c++) apply($sformatf("to_busy_c%0d", c), t, 6'b110011);
    check("to_before", 32'(timeout), 32'(0));
    apply("to_busy_c8", t, 6'b110011);
    check("to_set", 32'(timeout), 32'(1));
    apply("to_release", base, 6'b000000);
    apply("to_release2", base, 6'b000000);
    check("to_sticky", 32'(timeout), 32'(1));

    // ---- 7 stalls, break, 7 stalls: no timeout ----
    do_reset();
    for (int r = 0; r < 2; r++) begin
      for (int c = 1; c <= 7; c++) apply($sformatf("nto_r%0d_c%0d", r, c), t, 6'b110011);
      apply($sformatf("nto_break%0d", r), base, 6'b000000);
    end
    check("nto_clear", 32'(timeout), 32'(0));
    check("nto_count", 32'(stall_count), 32'(14));

    // ---- Saturation: 20 stall cycles hold count at 15 ----
    do_reset();
    for (int c = 1; c <= 20; c++) apply($sformatf("sat_c%0d", c), t, 6'b110011);
    check("sat_count", 32'(stall_count), 32'(15));
    check("sat_timeout", 32'(timeout), 32'(1));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/c5_pipe_ctrl.md
# c5_pipe_ctrl

Pipeline sequencing controller for the c5 core. It watches the fetch, decode, execute and memory stages and generates the per-stage stall, flush and bubble controls. The decode-stage register's stall input is driven from `O_stall_d`, and its NOP load from `O_flush_d`. It tracks an outstanding multi-cycle (mult/div) operation, counts stall cycles, and flags a stuck pipeline.

## Interface

Parameters:
- `TIMEOUT`, default 1024: consecutive fetch-stall cycles that set `O_timeout`.
- `CNT_W`, default 16: width of the stall-cycle counter.

Ports:
- `I_clk` in 1: clock, rising edge.
- `I_rst` in 1: reset, synchronous, active-high.
- `I_d_rs` in 5: rs index of the decode instruction.
- `I_d_rs_used` in 1: decode instruction reads rs.
- `I_d_rt` in 5: rt index of the decode instruction.
- `I_d_rt_used` in 1: decode instruction reads rt.
- `I_d_mc_use` in 1: decode instruction reads HI/LO or issues a mult/div.
- `I_e_rd` in 5: destination register of the execute instruction.
- `I_e_is_load` in 1: execute instruction is a load.
- `I_e_mc_start` in 1: execute instruction starts the multi-cycle unit.
- `I_e_redirect` in 1: taken branch/jump resolved in execute.
- `I_mc_done` in 1: one-cycle pulse, multi-cycle result valid.
- `I_m_busy` in 1: data memory not ready; memory stage must hold.
- `I_imem_ready` in 1: fetch data valid this cycle.
- `O_stall_f` out 1: hold PC / fetch.
- `O_stall_d` out 1: hold decode register.
- `O_flush_d` out 1: decode register loads NOP.
- `O_bubble_e` out 1: execute register loads NOP.
- `O_stall_e` out 1: hold execute register.
- `O_stall_m` out 1: hold memory register.
- `O_mc_busy` out 1: multi-cycle op outstanding (registered).
- `O_timeout` out 1: sticky stuck-pipeline flag (registered).
- `O_stall_count` out `CNT_W`: saturating count of `O_stall_d` cycles (registered).

## Operation

- **Control outputs.** Stall, flush and bubble outputs are combinational from the inputs and the state register. Priority, highest first:
  1. **Memory wait.** `I_m_busy` sets `O_stall_f/d/e/m`=1. `O_flush_d`=0 and `O_bubble_e`=0. The redirect is ignored; it is held in execute and acted on once the wait ends.
  2. **Redirect.** `I_e_redirect` sets `O_flush_d`=1 and `O_bubble_e`=1, killing the wrong-path instructions in F and D. All stalls are 0. This overrides load-use and mc hazards.
  3. **Load-use.** Active when `I_e_is_load`, `I_e_rd`≠0, and a used source (`I_d_rs` or `I_d_rt` with its `_used` bit set) equals `I_e_rd`. Response: `O_stall_f`=`O_stall_d`=1, `O_bubble_e`=1.
  4. **MC hazard.** Active when state is MC_BUSY, `I_d_mc_use`=1 and `I_mc_done`=0. Response: `O_stall_f`=`O_stall_d`=1, `O_bubble_e`=1. A `done` pulse releases the stall in the same cycle.
  5. **Fetch miss.** `!I_imem_ready` sets `O_stall_f`=1. It also sets `O_flush_d`=1 unless `O_stall_d`=1, in which case the hold wins.
- Register 0 never creates a hazard.
- **FSM (2 states).**
  - IDLE → MC_BUSY when `I_e_mc_start` and `!O_stall_e` (the op is accepted).
  - MC_BUSY → IDLE on `I_mc_done`.
  - If `I_mc_done` and an accepted `I_e_mc_start` occur in the same cycle, stay in MC_BUSY.
  - `I_e_mc_start` while MC_BUSY without done cannot legally occur (prevented by the MC hazard); the state is unchanged.
  - `O_mc_busy` = (state == MC_BUSY).
- **Stall counter.** Increments on each cycle with `O_stall_d`=1 and saturates at all-ones.
- **Timeout.** A run counter of width `$clog2(TIMEOUT+1)` counts consecutive cycles with `O_stall_f`=1 and clears on any cycle with `O_stall_f`=0. `O_timeout` sets when the run count reaches `TIMEOUT` and stays set until reset.

## Timing

- **Reset.** While `I_rst`=1, all stall/flush/bubble outputs are forced to 0. On the clock edge, state=IDLE, `O_mc_busy`=0, `O_timeout`=0, `O_stall_count`=0, run counter=0.
- **Reset mid-operation.** An outstanding mult/div is abandoned; a late `I_mc_done` in IDLE is ignored.
- **Latency.**
  - Control outputs have zero-cycle latency (same cycle as the inputs).
  - A load-use stall lasts exactly one cycle; after the bubble, the load has left execute.
  - `O_mc_busy` rises the cycle after an accepted start and falls the cycle after `I_mc_done`.
  - `O_timeout` asserts on the edge ending stall cycle `TIMEOUT`.
- **Simultaneous events.**
  - `I_m_busy` together with a redirect: stall only; the flush happens on the first cycle with `I_m_busy`=0.
  - Redirect together with a load-use hazard: flush wins and no stall is counted.

## Structure

- Add to `c5_parameters.v` (shared include):
  - FSM encodings `PC_IDLE`, `PC_MC_BUSY`.
  - `REG_ZERO`=5'd0.
  - Default `TIMEOUT`/`CNT_W` values.
- Sub-module `c5_stall_monitor` holds the saturating stall counter, the run counter and the sticky timeout. Inputs: `I_clk`, `I_rst`, `stall_d`, `stall_f`.
- Hazard priority logic and the FSM stay in `c5_pipe_ctrl`.

## Test plan

- **Load-use.** `I_e_is_load`=1, `I_e_rd`=5, `I_d_rs`=5, rs_used=1 → exactly 1 cycle of `O_stall_f/d`=1, `O_bubble_e`=1; `O_stall_count` becomes 1. Repeat with rd=0 → no stall.
- **Redirect during load-use.** Same cycle as the load-use hazard above → `O_flush_d`=1, `O_bubble_e`=1, stalls 0. With `I_m_busy`=1 added → only `O_stall_f/d/e/m`=1; the flush occurs the cycle `I_m_busy` drops.
- **Multi-cycle op.** Accepted `I_e_mc_start`, then `I_d_mc_use`=1 for 6 cycles, `I_mc_done` pulsed in cycle 6 → stall in cycles 1–5, release in cycle 6; `O_mc_busy` falls in cycle 7. Check the done+start same-cycle case stays busy.
- **Fetch miss.** `I_imem_ready`=0 for 3 cycles with no hazards → `O_stall_f`=1, `O_flush_d`=1, `O_stall_d`=0; combined with load-use → `O_stall_d`=1, `O_flush_d`=0.
- **Timeout.** `TIMEOUT`=8: `I_m_busy` held for 8 cycles → `O_timeout`=1 after cycle 8 and stays set after busy clears; 7 cycles, a break, then 7 cycles → stays 0.
- **Saturation and reset.** `CNT_W`=4 with 20 stall cycles → count holds at 15. Pulse `I_rst` mid-MC_BUSY → all registered outputs read 0 and state is IDLE.
